alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Instruction decode stage that produces the ALU's control inputs: it decodes one RV32I instruction per handshake into ALU control, branch control, shift amount, immediate and operand-select fields. The decoded fields are held in a registered ID/EX pipeline slot with valid/ready flow control and flush. It sits between instruction fetch and the ALU in the CPU pipeline.

## Interface
- DATAWIDTH, 32: instruction, PC and immediate width.
- SHIFT_WIDTH, 5: shift-amount width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- instr_i  in  DATAWIDTH  instruction word.
- pc_i  in  DATAWIDTH  PC of instr_i.
- valid_i  in  1  upstream has an instruction.
- ready_o  out  1  stage can accept.
- flush_i  in  1  kill all held instructions.
- valid_o  out  1  decoded slot valid.
- ready_i  in  1  downstream (ALU/EX) accepts.
- ALUctrl_o  out  4  ALU operation.
- BranchCtrl_o  out  3  branch condition.
- shift_o  out  SHIFT_WIDTH  immediate shift amount.
- imm_o  out  DATAWIDTH  sign-extended immediate.
- pc_o  out  DATAWIDTH  registered pc_i.
- rd_o, rs1_o, rs2_o  out  5 each  register indices.
- srca_pc_o  out  1  SrcA = PC (AUIPC, JAL).
- srcb_imm_o  out  1  SrcB = imm_o.
- regwrite_o  out  1  instruction writes rd.
- illegal_o  out  1  unsupported opcode/funct.

## Operation
- Input transfer: valid_i && ready_o at a rising edge. Output transfer: valid_o && ready_i.
- ALUctrl: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 PASSB.
- BranchCtrl: 000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 always (JAL/JALR).
- OP (0110011): ALU op from funct3/funct7[5]; srcb_imm_o=0; regwrite_o=1; shift_o=0.
- OP-IMM (0010011): I-imm; srcb_imm_o=1; SLLI/SRLI/SRAI set shift_o=instr[24:20]; SRAI when funct7[5]=1.
- LUI: PASSB, U-imm. AUIPC: ADD, srca_pc_o=1, U-imm.
- LOAD/STORE: ADD, I/S-imm; regwrite_o=1 for LOAD only.
- BRANCH: SUB, srcb_imm_o=0, B-imm, BranchCtrl from funct3; regwrite_o=0; funct3 010/011 illegal.
- JAL: ADD, srca_pc_o=1, J-imm, BranchCtrl=111. JALR: ADD, I-imm, BranchCtrl=111. Both write rd.
- Illegal (other opcode, bad funct3/funct7): illegal_o=1, ALUctrl ADD, BranchCtrl 000, regwrite_o=0; still handed downstream as valid.
- Unused fields are 0; rs1/rs2/rd are always raw instr bits.

## Timing
- Reset (rst_n=0 at edge): valid_o=0, ready_o=0 while rst_n=0; all data outputs 0. ready_o=1 in the first cycle after reset deassertion.
- Latency: 1 cycle, accept at edge N, valid_o high after edge N.
- Base ready_o = !valid_o || ready_i (combinational). Stall: valid_o=1, ready_i=0 holds all outputs stable.
- Simultaneous output and input transfer: slot is reloaded, no bubble.
- flush_i=1 at an edge: valid_o=0 after the edge and the skid entry is cleared. An input handshaking in that same cycle is discarded. Flush has priority over everything except reset.
- Reset mid-stall or with flush asserted: reset wins, all state cleared.

## Configuration
- DECODE_SKID_EN defined: a 2-entry skid buffer is added. ready_o becomes registered (high when the skid entry is empty). An input accepted while downstream stalls goes to the skid entry and is presented after the main slot drains, in order. Throughput is still 1/cycle.
- Not defined: single slot with combinational ready_o as above.

## Test plan
- Reset: rst_n=0 for 2 cycles -> valid_o=0, ready_o=0, all outputs 0; next cycle ready_o=1.
- 0x002081B3 (ADD x3,x1,x2) then 0x402081B3 back-to-back, ready_i=1 -> ALUctrl 0000 then 0001, rd=3, rs1=1, rs2=2, regwrite=1, one per cycle.
- 0x40335293 (SRAI x5,x6,3) -> ALUctrl 0111, shift_o=3, srcb_imm_o=1, rd=5, rs1=6.
- 0xFE209CE3 (BNE x1,x2,-8) -> BranchCtrl 010, ALUctrl 0001, imm_o=0xFFFFFFF8, regwrite_o=0.
- 0x00000000 -> illegal_o=1, regwrite_o=0, valid_o=1. Then ready_i=0 for 3 cycles -> outputs stable. Flush on the 2nd cycle -> valid_o=0.
- With DECODE_SKID_EN: 3 instructions streamed while ready_i=0 -> 2 accepted, then ready_o=0. Release ready_i -> drained in order.

Source files
------------

// File: rtl/alu_decode_stage.sv
// alu_decode_stage
//   Decodes one RV32I instruction per valid/ready handshake into ALU control,
//   branch control, shift amount, immediate and operand-select fields, and
//   holds them in a registered ID/EX slot. Sits between fetch and the ALU.
//
//   Optional feature macro: DECODE_SKID_EN
//     undefined : single output slot, ready_o = !valid_o || ready_i (comb).
//     defined   : an extra skid entry behind the output slot; ready_o is
//                 driven from register state (high while the skid is empty).
//
//   Ports
//     clk, rst_n          clock, synchronous active-low reset
//     instr_i, pc_i       instruction word and its PC
//     valid_i / ready_o   upstream handshake
//     flush_i             kill every held instruction
//     valid_o / ready_i   downstream (EX) handshake
//     ALUctrl_o           ALU operation
//     BranchCtrl_o        branch condition (111 = unconditional jump)
//     shift_o             immediate shift amount (shift-immediate ops only)
//     imm_o               sign-extended immediate
//     pc_o                PC of the decoded instruction
//     rd_o, rs1_o, rs2_o  raw register index fields
//     srca_pc_o           SrcA = PC (AUIPC, JAL)
//     srcb_imm_o          SrcB = imm_o
//     regwrite_o          instruction writes rd
//     illegal_o           unsupported opcode / funct encoding
module alu_decode_stage #(
  parameter int DATAWIDTH   = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATAWIDTH-1:0]   instr_i,
  input  logic [DATAWIDTH-1:0]   pc_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   flush_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [3:0]             ALUctrl_o,
  output logic [2:0]             BranchCtrl_o,
  output logic [SHIFT_WIDTH-1:0] shift_o,
  output logic [DATAWIDTH-1:0]   imm_o,
  output logic [DATAWIDTH-1:0]   pc_o,
  output logic [4:0]             rd_o,
  output logic [4:0]             rs1_o,
  output logic [4:0]             rs2_o,
  output logic                   srca_pc_o,
  output logic                   srcb_imm_o,
  output logic                   regwrite_o,
  output logic                   illegal_o
);

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic                   illegal;
    logic                   regwrite;
    logic                   srcb_imm;
    logic                   srca_pc;
    logic [4:0]             rs2;
    logic [4:0]             rs1;
    logic [4:0]             rd;
    logic [DATAWIDTH-1:0]   imm;
    logic [SHIFT_WIDTH-1:0] shift;
    logic [2:0]             branch;
    logic [3:0]             alu;
  } dec_t;

  // funct3 -> ALU op for the register and immediate arithmetic groups,
  // before funct7[5] selects SUB / SRA.
  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic dec_t decode(input logic [DATAWIDTH-1:0] ins);
    dec_t               d;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    d      = '0;
    d.rd   = ins[11:7];
    d.rs1  = ins[19:15];
    d.rs2  = ins[24:20];
    f3     = ins[14:12];
    f7     = ins[31:25];
    imm_i  = {{20{ins[31]}}, ins[31:20]};
    imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_u  = {ins[31:12], 12'b0};
    imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    case (ins[6:0])
      OPC_OP: begin
        d.regwrite = 1'b1;
        if (f7 == 7'b0000000)
          d.alu = base_alu(f3);
        else if (f7 == 7'b0100000 && f3 == 3'b000)
          d.alu = ALU_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101)
          d.alu = ALU_SRA;
        else
          d.illegal = 1'b1;
      end
      OPC_OPIMM: begin
        d.regwrite = 1'b1;
        d.srcb_imm = 1'b1;
        d.imm      = DATAWIDTH'(imm_i);
        d.alu      = base_alu(f3);
        if (f3 == 3'b001 || f3 == 3'b101) begin
          d.shift = SHIFT_WIDTH'(ins[24:20]);
          if (f3 == 3'b101 && f7 == 7'b0100000)
            d.alu = ALU_SRA;
          else if (f7 != 7'b0000000)
            d.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        d.regwrite = 1'b1;
        d.srcb_imm = 1'b1;
        d.imm      = DATAWIDTH'(imm_u);
        d.alu      = ALU_PASSB;
      end
      OPC_AUIPC: begin
        d.regwrite = 1'b1;
        d.srca_pc  = 1'b1;
        d.srcb_imm = 1'b1;
        d.imm      = DATAWIDTH'(imm_u);
      end
      OPC_LOAD: begin
        d.regwrite = 1'b1;
        d.srcb_imm = 1'b1;
        d.imm      = DATAWIDTH'(imm_i);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
          d.illegal = 1'b1;
      end
      OPC_STORE: begin
        d.srcb_imm = 1'b1;
        d.imm      = DATAWIDTH'(imm_s);
        if (f3[2] || f3 == 3'b011)
          d.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        d.alu = ALU_SUB;
        d.imm = DATAWIDTH'(imm_b);
        case (f3)
          3'b000:  d.branch = 3'b001;
          3'b001:  d.branch = 3'b010;
          3'b100:  d.branch = 3'b011;
          3'b101:  d.branch = 3'b100;
          3'b110:  d.branch = 3'b101;
          3'b111:  d.branch = 3'b110;
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        d.regwrite = 1'b1;
        d.srca_pc  = 1'b1;
        d.srcb_imm = 1'b1;
        d.imm      = DATAWIDTH'(imm_j);
        d.branch   = 3'b111;
      end
      OPC_JALR: begin
        d.regwrite = 1'b1;
        d.srcb_imm = 1'b1;
        d.imm      = DATAWIDTH'(imm_i);
        d.branch   = 3'b111;
        if (f3 != 3'b000)
          d.illegal = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    // An illegal instruction travels downstream as a harmless ADD with no
    // side effects; only the raw register fields are kept.
    if (d.illegal) begin
      d.alu      = ALU_ADD;
      d.branch   = 3'b000;
      d.regwrite = 1'b0;
      d.srca_pc  = 1'b0;
      d.srcb_imm = 1'b0;
      d.imm      = '0;
      d.shift    = '0;
    end
    return d;
  endfunction

  dec_t                 in_dec;
  dec_t                 slot_p1;
  logic [DATAWIDTH-1:0] pc_p1;
  logic                 vld_p1;
  logic                 acc;
  logic                 drain_ok;

  assign in_dec   = decode(instr_i);
  assign acc      = valid_i && ready_o;
  assign drain_ok = !vld_p1 || ready_i;

  // ---- ID -> ID/EX slot boundary ----
`ifdef DECODE_SKID_EN
  dec_t                 skid_p1;
  logic [DATAWIDTH-1:0] skid_pc_p1;
  logic                 skid_vld_p1;

  // Ready depends only on the skid flag (a register); rst_n gating keeps
  // the stage closed while reset is held.
  assign ready_o = rst_n && !skid_vld_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      slot_p1 <= '0;
      pc_p1   <= '0;
    end else if (flush_i) begin
      vld_p1 <= 1'b0;
    end else if (drain_ok) begin
      if (skid_vld_p1) begin
        vld_p1  <= 1'b1;
        slot_p1 <= skid_p1;
        pc_p1   <= skid_pc_p1;
      end else begin
        vld_p1 <= acc;
        if (acc) begin
          slot_p1 <= in_dec;
          pc_p1   <= pc_i;
        end
      end
    end
  end

  // The skid only fills while the main slot is stalled; when it is full
  // ready_o is low, so a draining cycle simply empties it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_vld_p1 <= 1'b0;
      skid_p1     <= '0;
      skid_pc_p1  <= '0;
    end else if (flush_i) begin
      skid_vld_p1 <= 1'b0;
    end else if (!drain_ok) begin
      if (acc) begin
        skid_vld_p1 <= 1'b1;
        skid_p1     <= in_dec;
        skid_pc_p1  <= pc_i;
      end
    end else begin
      skid_vld_p1 <= 1'b0;
    end
  end
`else
  assign ready_o = rst_n && drain_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      slot_p1 <= '0;
      pc_p1   <= '0;
    end else if (flush_i) begin
      vld_p1 <= 1'b0;
    end else if (drain_ok) begin
      vld_p1 <= acc;
      if (acc) begin
        slot_p1 <= in_dec;
        pc_p1   <= pc_i;
      end
    end
  end
`endif

  assign valid_o      = vld_p1;
  assign ALUctrl_o    = slot_p1.alu;
  assign BranchCtrl_o = slot_p1.branch;
  assign shift_o      = slot_p1.shift;
  assign imm_o        = slot_p1.imm;
  assign pc_o         = pc_p1;
  assign rd_o         = slot_p1.rd;
  assign rs1_o        = slot_p1.rs1;
  assign rs2_o        = slot_p1.rs2;
  assign srca_pc_o    = slot_p1.srca_pc;
  assign srcb_imm_o   = slot_p1.srcb_imm;
  assign regwrite_o   = slot_p1.regwrite;
  assign illegal_o    = slot_p1.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: hand-decoded RV32I vectors, stall,
// flush, reset and (with DECODE_SKID_EN) skid-buffer ordering.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_i, pc_i;
  logic        valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [3:0]  ALUctrl_o;
  logic [2:0]  BranchCtrl_o;
  logic [4:0]  shift_o;
  logic [31:0] imm_o, pc_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic        srca_pc_o, srcb_imm_o, regwrite_o, illegal_o;

  int n_cmp = 0;
  int n_bad = 0;

  alu_decode_stage #(.DATAWIDTH(32), .SHIFT_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .pc_i(pc_i),
    .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .ALUctrl_o(ALUctrl_o),
    .BranchCtrl_o(BranchCtrl_o), .shift_o(shift_o), .imm_o(imm_o),
    .pc_o(pc_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .srca_pc_o(srca_pc_o), .srcb_imm_o(srcb_imm_o),
    .regwrite_o(regwrite_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $error("FAIL %s", tag);
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    valid_i = v;
    instr_i = ins;
    pc_i    = pc;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    drive(1'b0, 32'h0, 32'h0);

    // Reset held two cycles
    tick(); tick();
    chk("rst_valid", valid_o === 1'b0);
    chk("rst_ready", ready_o === 1'b0);
    chk("rst_alu", ALUctrl_o === 4'b0000);
    chk("rst_imm", imm_o === 32'h0);
    chk("rst_pc", pc_o === 32'h0);
    chk("rst_regs", {rd_o, rs1_o, rs2_o} === 15'h0);
    chk("rst_flags", {srca_pc_o, srcb_imm_o, regwrite_o, illegal_o, BranchCtrl_o, shift_o} === 12'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", ready_o === 1'b1);

    // ADD x3,x1,x2 then SUB back-to-back
    drive(1'b1, 32'h002081B3, 32'h100);
    tick();
    chk("add_valid", valid_o === 1'b1);
    chk("add_alu", ALUctrl_o === 4'b0000);
    chk("add_regs", {rd_o, rs1_o, rs2_o} === {5'd3, 5'd1, 5'd2});
    chk("add_regwrite", regwrite_o === 1'b1);
    chk("add_srcb", srcb_imm_o === 1'b0);
    chk("add_pc", pc_o === 32'h100);
    drive(1'b1, 32'h402081B3, 32'h104);
    tick();
    chk("sub_valid", valid_o === 1'b1);
    chk("sub_alu", ALUctrl_o === 4'b0001);
    chk("sub_pc", pc_o === 32'h104);

    // SRAI x5,x6,3
    drive(1'b1, 32'h40335293, 32'h108);
    tick();
    chk("srai_alu", ALUctrl_o === 4'b0111);
    chk("srai_shift", shift_o === 5'd3);
    chk("srai_srcb", srcb_imm_o === 1'b1);
    chk("srai_rd_rs1", {rd_o, rs1_o} === {5'd5, 5'd6});
    chk("srai_imm", imm_o === 32'h403);

    // BNE x1,x2,-8
    drive(1'b1, 32'hFE209CE3, 32'h10C);
    tick();
    chk("bne_branch", BranchCtrl_o === 3'b010);
    chk("bne_alu", ALUctrl_o === 4'b0001);
    chk("bne_imm", imm_o === 32'hFFFFFFF8);
    chk("bne_regwrite", regwrite_o === 1'b0);
    chk("bne_srcb", srcb_imm_o === 1'b0);
    chk("bne_regs", {rd_o, rs1_o, rs2_o} === {5'd25, 5'd1, 5'd2});

    // All-zero word is illegal, then stall and flush on the 2nd stall cycle
    drive(1'b1, 32'h0, 32'h110);
    tick();
    chk("ill_valid", valid_o === 1'b1);
    chk("ill_flag", illegal_o === 1'b1);
    chk("ill_regwrite", regwrite_o === 1'b0);
    chk("ill_alu_br", {ALUctrl_o, BranchCtrl_o} === 7'h0);
    drive(1'b0, 32'h0, 32'h0);
    ready_i = 1'b0;
`ifndef DECODE_SKID_EN
    #1;
    chk("stall_ready_low", ready_o === 1'b0);
`endif
    tick();
    chk("stall1_valid", valid_o === 1'b1);
    chk("stall1_ill", illegal_o === 1'b1);
    chk("stall1_pc", pc_o === 32'h110);
    flush_i = 1'b1;
    drive(1'b1, 32'h002081B3, 32'h200);
    tick();
    chk("flush_valid", valid_o === 1'b0);
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("flush_stays_empty", valid_o === 1'b0);

    // Input handshaking in a flush cycle is discarded
    ready_i = 1'b1;
    flush_i = 1'b1;
    drive(1'b1, 32'h123453B7, 32'h300);
    tick();
    chk("flush_drop_valid", valid_o === 1'b0);
    flush_i = 1'b0;
    tick();
    // LUI x7,0x12345
    chk("lui_valid", valid_o === 1'b1);
    chk("lui_alu", ALUctrl_o === 4'b1010);
    chk("lui_imm", imm_o === 32'h12345000);
    chk("lui_flags", {srca_pc_o, srcb_imm_o, regwrite_o, rd_o} === {3'b011, 5'd7});

    // JAL x1,+16 taken while LUI drains (no bubble)
    drive(1'b1, 32'h010000EF, 32'h304);
    tick();
    chk("jal_valid", valid_o === 1'b1);
    chk("jal_branch", BranchCtrl_o === 3'b111);
    chk("jal_imm", imm_o === 32'h10);
    chk("jal_flags", {ALUctrl_o, srca_pc_o, regwrite_o, rd_o} === {4'b0000, 2'b11, 5'd1});
    chk("jal_pc", pc_o === 32'h304);

    // Reset during a stall with flush asserted clears everything
    drive(1'b0, 32'h0, 32'h0);
    ready_i = 1'b0;
    tick();
    chk("jal_stall_imm", imm_o === 32'h10);
    rst_n = 1'b0;
    flush_i = 1'b1;
    tick();
    chk("rst2_valid", valid_o === 1'b0);
    chk("rst2_data", {imm_o, pc_o} === 64'h0);
    chk("rst2_flags", {BranchCtrl_o, regwrite_o, srca_pc_o} === 5'h0);
    rst_n = 1'b1;
    flush_i = 1'b0;

`ifdef DECODE_SKID_EN
    // Three offered while EX stalls: two accepted, then ready_o drops
    drive(1'b1, 32'h002081B3, 32'h400);
    tick();
    drive(1'b1, 32'h402081B3, 32'h404);
    tick();
    chk("skid_ready_low", ready_o === 1'b0);
    chk("skid_head_alu", ALUctrl_o === 4'b0000);
    drive(1'b1, 32'h40335293, 32'h408);
    tick();
    chk("skid_hold_ready", ready_o === 1'b0);
    chk("skid_hold_pc", pc_o === 32'h400);
    ready_i = 1'b1;
    tick();
    chk("skid_drain2_alu", ALUctrl_o === 4'b0001);
    chk("skid_drain2_pc", pc_o === 32'h404);
    tick();
    chk("skid_drain3_alu", ALUctrl_o === 4'b0111);
    chk("skid_drain3_pc", pc_o === 32'h408);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("skid_empty", valid_o === 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
